core_run_controller: RTL and testbench

Parametrised run controller that sequences reset, execution and termination of the single-cycle RISC-V core under simulation or on FPGA. It replaces the fixed reset pulse and fixed run length with a state machine. The machine holds the core in reset for a programmable number of cycles and releases it. It then ends the run either on a tohost store or on a cycle-budget timeout. It sits beside `Single_Cycle_Top`, driving its active-low reset, snooping its data-memory write port and retire strobe, and exposing pass/fail status and performance counters.

---
 rtl/core_run_pkg.sv | 17 +
 rtl/sat_counter.sv | 24 ++
 rtl/core_run_controller.sv | 131 +++++++++++++
 tb/tb_core_run_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_run_pkg.sv
// core_run_pkg: shared types and constants for the core run controller.
//   run_state_t          controller state (IDLE, RESET, RUN, DONE)
//   TOHOST_ADDR_DEFAULT  store address that ends a run
//   PASS_VALUE           tohost word that marks a passing run
package core_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DONE
  } run_state_t;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FFC;
  localparam logic [31:0] PASS_VALUE          = 32'h0000_0001;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk, rst  clock and synchronous active-high reset
//   clear     synchronous clear (priority over enable)
//   en        count this cycle
//   count     current value
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/core_run_controller.sv
// core_run_controller: sequences reset, execution and termination of the core.
// Holds the core in reset for RESET_CYCLES, runs it until a tohost store or
// until the MAX_CYCLES budget is spent, then freezes it and reports status.
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin/restart a run (from IDLE or DONE)
//   core_rst_n               active-low reset to the core
//   mem_we/mem_addr/mem_wdata snooped core data-memory write port
//   retire                   instruction retired this cycle
//   running, done            RUN / DONE state flags
//   pass, timeout, fail_code run result, valid while done
//   cycle_count, instret_count saturating RUN-cycle and retire counters
module core_run_controller
  import core_run_pkg::*;
#(
  parameter int unsigned      XLEN         = 32,
  parameter int unsigned      RESET_CYCLES = 2,
  parameter int unsigned      MAX_CYCLES   = 1024,
  parameter int unsigned      CNT_W        = 32,
  parameter logic [XLEN-1:0]  TOHOST_ADDR  = XLEN'(TOHOST_ADDR_DEFAULT),
  parameter bit               AUTO_START   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             core_rst_n,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  input  logic             retire,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-2:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  localparam int unsigned     RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned     BUD_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [BUD_W-1:0] BUD_LAST = BUD_W'(MAX_CYCLES - 1);

  run_state_t       state;
  logic [RST_W-1:0] rst_cnt;
  // Full-width budget counter: the reported counters may be narrower and saturate.
  logic [BUD_W-1:0] budget;

  logic term_c;
  logic enter_reset_c;
  logic in_run_c;

  assign term_c        = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
  assign enter_reset_c = ((state == ST_IDLE) && (start || AUTO_START)) ||
                         ((state == ST_DONE) && start);
  assign in_run_c      = (state == ST_RUN);

  // Run FSM with registered outputs and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      core_rst_n <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      fail_code  <= '0;
      rst_cnt    <= '0;
      budget     <= '0;
    end else if (enter_reset_c) begin
      state      <= ST_RESET;
      core_rst_n <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      fail_code  <= '0;
      rst_cnt    <= '0;
      budget     <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state      <= ST_RUN;
            core_rst_n <= 1'b1;
            running    <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        ST_RUN: begin
          budget <= budget + BUD_W'(1);
          // A terminating store beats a timeout on the same cycle.
          if (term_c) begin
            pass       <= (mem_wdata == XLEN'(PASS_VALUE));
            fail_code  <= mem_wdata[XLEN-1:1];
            state      <= ST_DONE;
            core_rst_n <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b1;
          end else if (budget == BUD_LAST) begin
            timeout    <= 1'b1;
            pass       <= 1'b0;
            state      <= ST_DONE;
            core_rst_n <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (enter_reset_c),
    .en    (in_run_c),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (enter_reset_c),
    .en    (in_run_c && retire),
    .count (instret_count)
  );

endmodule

// File: tb/tb_core_run_controller.sv
// tb_core_run_controller: three controller instances (defaults; 16-cycle
// budget; AUTO_START=0 with 3-cycle reset and 4-bit counters) driven with
// random bus noise plus scripted terminations, compared every cycle against
// a behavioural model of the run rules.
module tb_core_run_controller;

  localparam logic [31:0] TOHOST = 32'h0000_0FFC;
  localparam int PH_IDLE = 0, PH_RESET = 1, PH_RUN = 2, PH_DONE = 3;
  localparam int N_CYC = 1500;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        we;
    logic        retire;
    logic [31:0] addr;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    int          phase;
    int          rst_left;
    longint      runs;
    longint      rets;
    bit          pass;
    bit          tout;
    logic [30:0] fcode;
  } mdl_t;

  int     p_rc   [3] = '{2, 2, 3};
  int     p_mc   [3] = '{1024, 16, 40};
  bit     p_auto [3] = '{1'b1, 1'b1, 1'b0};
  longint p_cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

  logic  clk = 1'b0;
  stim_t st [3];
  wire [99:0] ob [3];  // {rst_n, running, done, pass, timeout, fail_code[30:0], cycles, instret}

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  core_run_controller #(.XLEN(32), .RESET_CYCLES(2), .MAX_CYCLES(1024), .CNT_W(32),
                        .TOHOST_ADDR(32'h0000_0FFC), .AUTO_START(1'b1)) u_dut_a (
    .clk(clk), .rst(st[0].rst), .start(st[0].start), .core_rst_n(ob[0][99]),
    .mem_we(st[0].we), .mem_addr(st[0].addr), .mem_wdata(st[0].wdata), .retire(st[0].retire),
    .running(ob[0][98]), .done(ob[0][97]), .pass(ob[0][96]), .timeout(ob[0][95]),
    .fail_code(ob[0][94:64]), .cycle_count(ob[0][63:32]), .instret_count(ob[0][31:0])
  );

  core_run_controller #(.XLEN(32), .RESET_CYCLES(2), .MAX_CYCLES(16), .CNT_W(32),
                        .TOHOST_ADDR(32'h0000_0FFC), .AUTO_START(1'b1)) u_dut_b (
    .clk(clk), .rst(st[1].rst), .start(st[1].start), .core_rst_n(ob[1][99]),
    .mem_we(st[1].we), .mem_addr(st[1].addr), .mem_wdata(st[1].wdata), .retire(st[1].retire),
    .running(ob[1][98]), .done(ob[1][97]), .pass(ob[1][96]), .timeout(ob[1][95]),
    .fail_code(ob[1][94:64]), .cycle_count(ob[1][63:32]), .instret_count(ob[1][31:0])
  );

  core_run_controller #(.XLEN(32), .RESET_CYCLES(3), .MAX_CYCLES(40), .CNT_W(4),
                        .TOHOST_ADDR(32'h0000_0FFC), .AUTO_START(1'b0)) u_dut_c (
    .clk(clk), .rst(st[2].rst), .start(st[2].start), .core_rst_n(ob[2][99]),
    .mem_we(st[2].we), .mem_addr(st[2].addr), .mem_wdata(st[2].wdata), .retire(st[2].retire),
    .running(ob[2][98]), .done(ob[2][97]), .pass(ob[2][96]), .timeout(ob[2][95]),
    .fail_code(ob[2][94:64]), .cycle_count(ob[2][35:32]), .instret_count(ob[2][3:0])
  );
  assign ob[2][63:36] = '0;
  assign ob[2][31:4]  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input longint v, input longint mx);
    return (v > mx) ? 32'(mx) : 32'(v);
  endfunction

  // One clock edge of the run rules for instance i.
  function automatic mdl_t step(input mdl_t s, input stim_t in, input int i);
    mdl_t n;
    bit   term;
    n    = s;
    term = in.we && (in.addr == TOHOST) && in.wdata[0];
    if (in.rst) begin
      n = '{default: 0};
      n.phase = PH_IDLE;
      return n;
    end
    if ((s.phase == PH_IDLE && (in.start || p_auto[i])) || (s.phase == PH_DONE && in.start)) begin
      n = '{default: 0};
      n.phase    = PH_RESET;
      n.rst_left = p_rc[i];
      return n;
    end
    if (s.phase == PH_RESET) begin
      n.rst_left = s.rst_left - 1;
      if (n.rst_left == 0) n.phase = PH_RUN;
    end else if (s.phase == PH_RUN) begin
      n.runs = s.runs + 1;
      if (in.retire) n.rets = s.rets + 1;
      if (term) begin
        n.pass  = (in.wdata == 32'd1);
        n.fcode = in.wdata[31:1];
        n.phase = PH_DONE;
      end else if (n.runs == longint'(p_mc[i])) begin
        n.tout  = 1'b1;
        n.phase = PH_DONE;
      end
    end
    return n;
  endfunction

  mdl_t        m        [3];
  int          kr       [3];  // completed runs per instance
  int          wait_cnt [3];
  int          target   [3];
  logic [31:0] tval     [3];
  bit          mid_rst = 1'b0;

  initial begin
    stim_t       s;
    int          ph, rn, prev;
    bit          do_st;
    logic [31:0] v, o_st, e_st;
    logic [99:0] o;
    bit          new_done [3];

    for (int i = 0; i < 3; i++) begin
      m[i] = '{default: 0};
      kr[i] = 0; wait_cnt[i] = 0; target[i] = 0; tval[i] = 32'd1;
      st[i] = '0;
    end

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      // Drive: random non-terminating bus noise plus scripted events per instance.
      for (int i = 0; i < 3; i++) begin
        s = '0;
        s.rst    = (cyc < 2);
        s.retire = 1'($urandom_range(0, 1));
        s.we     = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) begin
          s.addr  = TOHOST;
          s.wdata = $urandom & 32'hFFFF_FFFE;
        end else begin
          s.addr  = $urandom & 32'hFFFF_FFF8;
          s.wdata = $urandom;
        end
        ph = m[i].phase;
        rn = int'(m[i].runs);
        if (ph == PH_IDLE || ph == PH_DONE) begin
          s.start = (wait_cnt[i] >= 3);
        end else begin
          s.start = ($urandom_range(0, 7) == 0);
          if (ph == PH_RUN) begin
            do_st = 1'b0;
            v     = 32'd0;
            case (i)
              0: begin
                if (kr[0] == 0) begin
                  s.retire = (rn < 30);
                  if (rn == 39) begin do_st = 1'b1; v = 32'd1; end
                end else if (kr[0] == 1) begin
                  if (rn == 5)  begin do_st = 1'b1; v = 32'h6; end
                  if (rn == 12) begin do_st = 1'b1; v = 32'h7; end
                end else if (rn + 1 == target[0]) begin
                  do_st = 1'b1; v = tval[0];
                end
              end
              1: begin
                if (kr[1] == 1 && rn == 15) begin do_st = 1'b1; v = 32'd1; end
                else if (kr[1] == 2 && rn == 0) begin do_st = 1'b1; v = 32'd1; end
                else if (kr[1] >= 3 && rn + 1 == target[1]) begin do_st = 1'b1; v = tval[1]; end
              end
              default: begin
                if (kr[2] == 0 && !mid_rst) begin
                  if (rn == 9) begin s.rst = 1'b1; mid_rst = 1'b1; end
                end else if (kr[2] == 0) begin
                  s.retire = 1'b1;
                end else if (rn + 1 == target[2]) begin
                  do_st = 1'b1; v = tval[2];
                end
              end
            endcase
            if (do_st) begin
              s.we = 1'b1; s.addr = TOHOST; s.wdata = v;
            end
          end
        end
        st[i] = s;
      end

      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        prev = m[i].phase;
        m[i] = step(m[i], st[i], i);
        if (m[i].phase == PH_RESET && prev != PH_RESET) begin
          target[i] = $urandom_range(1, (i == 1) ? 20 : 60);
          tval[i]   = ($urandom_range(0, 1) == 1) ? 32'd1 : ($urandom | 32'd1);
        end
        new_done[i] = (m[i].phase == PH_DONE && prev != PH_DONE);
        wait_cnt[i] = (m[i].phase == PH_IDLE || m[i].phase == PH_DONE) ? wait_cnt[i] + 1 : 0;
      end

      #1;
      for (int i = 0; i < 3; i++) begin
        o    = ob[i];
        o_st = {27'd0, o[99:95]};
        e_st = {27'd0, m[i].phase == PH_RUN, m[i].phase == PH_RUN, m[i].phase == PH_DONE,
                m[i].pass, m[i].tout};
        check($sformatf("dut%0d_status", i), o_st, e_st);
        check($sformatf("dut%0d_fail_code", i), {1'b0, o[94:64]}, {1'b0, m[i].fcode});
        check($sformatf("dut%0d_cycles", i), o[63:32], sat(m[i].runs, p_cmax[i]));
        check($sformatf("dut%0d_instret", i), o[31:0], sat(m[i].rets, p_cmax[i]));

        if (i == 2 && mid_rst && kr[2] == 0 && m[2].phase == PH_IDLE)
          check("c_idle_rst_n", {31'd0, o[99]}, 32'd0);

        if (new_done[i]) begin
          case (i)
            0: begin
              if (kr[0] == 0) begin
                check("a_cycles40", o[63:32], 32'd40);
                check("a_instret30", o[31:0], 32'd30);
                check("a_pass", {30'd0, o[96], o[95]}, 32'b10);
                check("a_rst_n_low", {31'd0, o[99]}, 32'd0);
              end else if (kr[0] == 1) begin
                check("a_fail_pass", {31'd0, o[96]}, 32'd0);
                check("a_fail_code", {1'b0, o[94:64]}, 32'd3);
                check("a_fail_cycles", o[63:32], 32'd13);
              end
            end
            1: begin
              if (kr[1] == 0) begin
                check("b_timeout", {30'd0, o[96], o[95]}, 32'b01);
                check("b_timeout_cycles", o[63:32], 32'd16);
              end else if (kr[1] == 1) begin
                check("b_store_wins", {30'd0, o[96], o[95]}, 32'b10);
                check("b_store_cycles", o[63:32], 32'd16);
              end else if (kr[1] == 2) begin
                check("b_first_cycle", o[63:32], 32'd1);
              end
            end
            default: begin
              if (kr[2] == 0) begin
                check("c_sat_cycles", o[63:32], 32'd15);
                check("c_sat_instret", o[31:0], 32'd15);
                check("c_timeout40", {31'd0, o[95]}, 32'd1);
              end
            end
          endcase
          kr[i]++;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
